// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl
// Brief    : Multi-cycle control sequencer for the MIPS core. Steps the
//            shared datapath through fetch, decode, execute, memory and
//            write-back, one state per cycle, with req/ack memory waits.
// Ports    : clk, rst (async, active-low)
//            opcode/funct  - latched IR fields
//            zero          - ALU zero flag (branch condition)
//            mem_ack       - memory access completes this cycle
//            mem_req/mem_we/iord, ir_wr, pc_wr, pc_src, alusrc_a/b, aluop,
//            extop, regwr, reg_dst, memtoreg - datapath controls
//            illegal (sticky), state (debug), retired (instruction count)
// Revision : 1.0 - initial release
// ============================================================================
module mc_ctrl #(
  parameter logic [1:0] RST_PC_SRC = 2'b00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        ir_wr,
  output logic        pc_wr,
  output logic [1:0]  pc_src,
  output logic        alusrc_a,
  output logic [1:0]  alusrc_b,
  output logic [2:0]  aluop,
  output logic [1:0]  extop,
  output logic        regwr,
  output logic [1:0]  reg_dst,
  output logic [1:0]  memtoreg,
  output logic        illegal,
  output logic [3:0]  state,
  output logic [31:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WB   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ALU_WB   = 4'd10,
    S_HALT     = 4'd15
  } state_t;

  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_OP_ORI   = 6'b001101;
  localparam logic [5:0] c_OP_LUI   = 6'b001111;
  localparam logic [5:0] c_OP_ADDI  = 6'b001000;
  localparam logic [5:0] c_OP_LW    = 6'b100011;
  localparam logic [5:0] c_OP_SW    = 6'b101011;
  localparam logic [5:0] c_OP_BEQ   = 6'b000100;
  localparam logic [5:0] c_OP_J     = 6'b000010;
  localparam logic [5:0] c_OP_JAL   = 6'b000011;

  localparam logic [5:0] c_FN_ADDU  = 6'b100001;
  localparam logic [5:0] c_FN_SUBU  = 6'b100011;
  localparam logic [5:0] c_FN_SLT   = 6'b101010;
  localparam logic [5:0] c_FN_JR    = 6'b001000;

  localparam logic [2:0] c_ALU_ADD  = 3'b000;
  localparam logic [2:0] c_ALU_SUB  = 3'b001;
  localparam logic [2:0] c_ALU_OR   = 3'b010;
  localparam logic [2:0] c_ALU_SLT  = 3'b011;
  localparam logic [2:0] c_ALU_PASS = 3'b100;

  state_t      r_state;
  state_t      w_next;
  logic        r_illegal;
  logic [31:0] r_retired;

  logic w_rtype;
  assign w_rtype = (opcode == c_OP_RTYPE);

  // Next-state and control decode. Outputs are Moore from the state and IR
  // fields, except the FETCH ack-gated writes and the zero-gated branch.
  always_comb begin
    w_next   = r_state;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    iord     = 1'b0;
    ir_wr    = 1'b0;
    pc_wr    = 1'b0;
    pc_src   = 2'b00;
    alusrc_a = 1'b0;
    alusrc_b = 2'b00;
    aluop    = c_ALU_ADD;
    extop    = 2'b00;
    regwr    = 1'b0;
    reg_dst  = 2'b00;
    memtoreg = 2'b00;

    case (r_state)
      S_FETCH: begin
        mem_req  = 1'b1;
        alusrc_b = 2'b01;
        if (mem_ack) begin
          ir_wr  = 1'b1;
          pc_wr  = 1'b1;
          w_next = S_DECODE;
        end
      end
      S_DECODE: begin
        // Precompute the branch target into ALUOut.
        alusrc_b = 2'b11;
        if (w_rtype) begin
          if (funct == c_FN_ADDU || funct == c_FN_SUBU || funct == c_FN_SLT)
            w_next = S_EXEC_R;
          else if (funct == c_FN_JR)
            w_next = S_JUMP;
          else
            w_next = S_HALT;
        end else begin
          case (opcode)
            c_OP_ORI, c_OP_LUI, c_OP_ADDI: w_next = S_EXEC_I;
            c_OP_LW, c_OP_SW:              w_next = S_MEM_ADDR;
            c_OP_BEQ:                      w_next = S_BRANCH;
            c_OP_J, c_OP_JAL:              w_next = S_JUMP;
            default:                       w_next = S_HALT;
          endcase
        end
      end
      S_EXEC_R: begin
        alusrc_a = 1'b1;
        case (funct)
          c_FN_SUBU: aluop = c_ALU_SUB;
          c_FN_SLT:  aluop = c_ALU_SLT;
          default:   aluop = c_ALU_ADD;
        endcase
        w_next = S_ALU_WB;
      end
      S_EXEC_I: begin
        alusrc_a = 1'b1;
        alusrc_b = 2'b10;
        case (opcode)
          c_OP_ORI: begin extop = 2'b00; aluop = c_ALU_OR;   end
          c_OP_LUI: begin extop = 2'b10; aluop = c_ALU_PASS; end
          default:  begin extop = 2'b01; aluop = c_ALU_ADD;  end
        endcase
        w_next = S_ALU_WB;
      end
      S_ALU_WB: begin
        regwr   = 1'b1;
        reg_dst = w_rtype ? 2'b01 : 2'b00;
        w_next  = S_FETCH;
      end
      S_MEM_ADDR: begin
        alusrc_a = 1'b1;
        alusrc_b = 2'b10;
        extop    = 2'b01;
        w_next   = (opcode == c_OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ack) w_next = S_MEM_WB;
      end
      S_MEM_WB: begin
        regwr    = 1'b1;
        memtoreg = 2'b01;
        w_next   = S_FETCH;
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        if (mem_ack) w_next = S_FETCH;
      end
      S_BRANCH: begin
        alusrc_a = 1'b1;
        aluop    = c_ALU_SUB;
        pc_src   = 2'b01;
        pc_wr    = zero;
        w_next   = S_FETCH;
      end
      S_JUMP: begin
        pc_wr = 1'b1;
        if (w_rtype) begin
          pc_src = 2'b11;
        end else begin
          pc_src = 2'b10;
          if (opcode == c_OP_JAL) begin
            regwr    = 1'b1;
            reg_dst  = 2'b10;
            memtoreg = 2'b10;
          end
        end
        w_next = S_FETCH;
      end
      S_HALT: begin
        w_next = S_HALT;
      end
      default: begin
        w_next = S_FETCH;
      end
    endcase

    // Reset must kill any in-flight request immediately, not at the next edge.
    if (!rst) begin
      mem_req = 1'b0;
      mem_we  = 1'b0;
      ir_wr   = 1'b0;
      pc_wr   = 1'b0;
      regwr   = 1'b0;
      pc_src  = RST_PC_SRC;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
      r_retired <= 32'd0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE && w_next == S_HALT)
        r_illegal <= 1'b1;
      if (r_state != S_FETCH && w_next == S_FETCH)
        r_retired <= r_retired + 32'd1;
    end
  end

  assign state   = r_state;
  assign illegal = r_illegal;
  assign retired = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_ctrl
// Brief    : Directed self-checking bench for mc_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_ctrl;

  logic        clk;
  logic        rst;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic        mem_ack;
  logic        mem_req;
  logic        mem_we;
  logic        iord;
  logic        ir_wr;
  logic        pc_wr;
  logic [1:0]  pc_src;
  logic        alusrc_a;
  logic [1:0]  alusrc_b;
  logic [2:0]  aluop;
  logic [1:0]  extop;
  logic        regwr;
  logic [1:0]  reg_dst;
  logic [1:0]  memtoreg;
  logic        illegal;
  logic [3:0]  state;
  logic [31:0] retired;

  int checks   = 0;
  int failures = 0;

  mc_ctrl #(.RST_PC_SRC(2'b10)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_wr(ir_wr), .pc_wr(pc_wr), .pc_src(pc_src), .alusrc_a(alusrc_a),
    .alusrc_b(alusrc_b), .aluop(aluop), .extop(extop), .regwr(regwr),
    .reg_dst(reg_dst), .memtoreg(memtoreg), .illegal(illegal),
    .state(state), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Leaves the bench 1ns after a rising edge with reset released.
  task automatic do_reset();
    mem_ack = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; mem_ack = 1'b1; zero = 1'b0;
    opcode = 6'b000000; funct = 6'b100001;
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if (state !== 4'd0 || illegal !== 1'b0 || retired !== 32'd0) begin
      failures++;
      $display("FAIL reset_regs state=%0d illegal=%0b retired=%0d exp 0/0/0", state, illegal, retired);
    end
    checks++;
    if (pc_src !== 2'b10) begin
      failures++;
      $display("FAIL reset_pc_src got=%b exp=10", pc_src);
    end
    checks++;
    if ({mem_req, mem_we, ir_wr, pc_wr, regwr} !== 5'b0) begin
      failures++;
      $display("FAIL reset_enables got=%b exp=00000", {mem_req, mem_we, ir_wr, pc_wr, regwr});
    end
    rst = 1'b1; #1;
    checks++;
    if (mem_req !== 1'b1 || iord !== 1'b0 || alusrc_b !== 2'b01 || ir_wr !== 1'b1 || pc_src !== 2'b00) begin
      failures++;
      $display("FAIL release_fetch req=%b iord=%b srcb=%b ir_wr=%b pc_src=%b exp 1/0/01/1/00",
               mem_req, iord, alusrc_b, ir_wr, pc_src);
    end
  endtask

  task automatic test_rtype();
    logic [3:0] exp_st [5];
    exp_st = '{4'd0, 4'd1, 4'd2, 4'd10, 4'd0};
    do_reset();
    opcode = 6'b000000; funct = 6'b100001; mem_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (state !== exp_st[i]) begin
        failures++;
        $display("FAIL addu_state[%0d] got=%0d exp=%0d", i, state, exp_st[i]);
      end
      if (i == 1) begin
        checks++;
        if (alusrc_a !== 1'b0 || alusrc_b !== 2'b11 || aluop !== 3'b000) begin
          failures++;
          $display("FAIL decode_alu a=%b b=%b op=%b exp 0/11/000", alusrc_a, alusrc_b, aluop);
        end
      end
      if (i == 2) begin
        checks++;
        if (alusrc_a !== 1'b1 || alusrc_b !== 2'b00 || aluop !== 3'b000 || regwr !== 1'b0) begin
          failures++;
          $display("FAIL addu_exec a=%b b=%b op=%b regwr=%b exp 1/00/000/0", alusrc_a, alusrc_b, aluop, regwr);
        end
      end
      if (i == 3) begin
        checks++;
        if (regwr !== 1'b1 || reg_dst !== 2'b01 || memtoreg !== 2'b00 || pc_wr !== 1'b0) begin
          failures++;
          $display("FAIL addu_wb regwr=%b dst=%b m2r=%b pc_wr=%b exp 1/01/00/0", regwr, reg_dst, memtoreg, pc_wr);
        end
      end
      if (i == 4) begin
        checks++;
        if (retired !== 32'd1) begin
          failures++;
          $display("FAIL addu_retired got=%0d exp=1", retired);
        end
      end
      @(posedge clk); #1;
    end
    // slt: only the EXEC_R aluop differs.
    funct = 6'b101010;
    @(posedge clk); #1; #1;
    checks++;
    if (state !== 4'd2 || aluop !== 3'b011) begin
      failures++;
      $display("FAIL slt_exec state=%0d aluop=%b exp 2/011", state, aluop);
    end
    @(posedge clk); #1; @(posedge clk); #1;
  endtask

  task automatic test_itype();
    do_reset();
    opcode = 6'b001111; funct = 6'b000000; mem_ack = 1'b1;
    @(posedge clk); #1; @(posedge clk); #1; #1;
    checks++;
    if (state !== 4'd3 || alusrc_a !== 1'b1 || alusrc_b !== 2'b10 || extop !== 2'b10 || aluop !== 3'b100) begin
      failures++;
      $display("FAIL lui_exec state=%0d a=%b b=%b ext=%b op=%b exp 3/1/10/10/100",
               state, alusrc_a, alusrc_b, extop, aluop);
    end
    @(posedge clk); #1;
    checks++;
    if (state !== 4'd10 || regwr !== 1'b1 || reg_dst !== 2'b00) begin
      failures++;
      $display("FAIL lui_wb state=%0d regwr=%b dst=%b exp 10/1/00", state, regwr, reg_dst);
    end
    opcode = 6'b001101;
    @(posedge clk); #1; @(posedge clk); #1; @(posedge clk); #1;
    checks++;
    if (state !== 4'd3 || extop !== 2'b00 || aluop !== 3'b010) begin
      failures++;
      $display("FAIL ori_exec state=%0d ext=%b op=%b exp 3/00/010", state, extop, aluop);
    end
    @(posedge clk); #1; @(posedge clk); #1;
    checks++;
    if (state !== 4'd0 || retired !== 32'd2) begin
      failures++;
      $display("FAIL itype_retired state=%0d retired=%0d exp 0/2", state, retired);
    end
  endtask

  task automatic test_lw_wait();
    logic [3:0] exp_st [11];
    logic       ack_v  [11];
    exp_st = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd4, 4'd5, 4'd5, 4'd5, 4'd5, 4'd6, 4'd0};
    ack_v  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    do_reset();
    opcode = 6'b100011; funct = 6'b000000;
    for (int i = 0; i < 11; i++) begin
      mem_ack = ack_v[i];
      #1;
      checks++;
      if (state !== exp_st[i]) begin
        failures++;
        $display("FAIL lw_state[%0d] got=%0d exp=%0d", i, state, exp_st[i]);
      end
      if (i < 3) begin
        checks++;
        if (mem_req !== 1'b1 || iord !== 1'b0 || ir_wr !== ack_v[i]) begin
          failures++;
          $display("FAIL lw_fetch[%0d] req=%b iord=%b ir_wr=%b exp 1/0/%b", i, mem_req, iord, ir_wr, ack_v[i]);
        end
      end
      if (i == 4) begin
        checks++;
        if (mem_req !== 1'b0 || extop !== 2'b01 || alusrc_b !== 2'b10 || alusrc_a !== 1'b1) begin
          failures++;
          $display("FAIL lw_addr req=%b ext=%b b=%b a=%b exp 0/01/10/1", mem_req, extop, alusrc_b, alusrc_a);
        end
      end
      if (i >= 5 && i <= 8) begin
        checks++;
        if (mem_req !== 1'b1 || iord !== 1'b1 || mem_we !== 1'b0) begin
          failures++;
          $display("FAIL lw_rd[%0d] req=%b iord=%b we=%b exp 1/1/0", i, mem_req, iord, mem_we);
        end
      end
      if (i == 9) begin
        checks++;
        if (regwr !== 1'b1 || memtoreg !== 2'b01 || reg_dst !== 2'b00 || mem_req !== 1'b0) begin
          failures++;
          $display("FAIL lw_wb regwr=%b m2r=%b dst=%b req=%b exp 1/01/00/0", regwr, memtoreg, reg_dst, mem_req);
        end
      end
      if (i == 10) begin
        checks++;
        if (retired !== 32'd1) begin
          failures++;
          $display("FAIL lw_retired got=%0d exp=1", retired);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_beq();
    do_reset();
    opcode = 6'b000100; funct = 6'b000000; mem_ack = 1'b1; zero = 1'b1;
    @(posedge clk); #1; @(posedge clk); #1; #1;
    checks++;
    if (state !== 4'd8 || pc_wr !== 1'b1 || pc_src !== 2'b01 || aluop !== 3'b001 || regwr !== 1'b0) begin
      failures++;
      $display("FAIL beq_taken state=%0d pc_wr=%b pc_src=%b op=%b regwr=%b exp 8/1/01/001/0",
               state, pc_wr, pc_src, aluop, regwr);
    end
    @(posedge clk); #1;
    checks++;
    if (state !== 4'd0 || retired !== 32'd1) begin
      failures++;
      $display("FAIL beq_taken_done state=%0d retired=%0d exp 0/1", state, retired);
    end
    zero = 1'b0;
    @(posedge clk); #1; @(posedge clk); #1; #1;
    checks++;
    if (state !== 4'd8 || pc_wr !== 1'b0) begin
      failures++;
      $display("FAIL beq_not_taken state=%0d pc_wr=%b exp 8/0", state, pc_wr);
    end
    @(posedge clk); #1;
    checks++;
    if (state !== 4'd0 || retired !== 32'd2) begin
      failures++;
      $display("FAIL beq_nt_done state=%0d retired=%0d exp 0/2", state, retired);
    end
  endtask

  task automatic test_jumps();
    do_reset();
    opcode = 6'b000011; funct = 6'b000000; mem_ack = 1'b1;
    @(posedge clk); #1; @(posedge clk); #1; #1;
    checks++;
    if (state !== 4'd9 || pc_wr !== 1'b1 || pc_src !== 2'b10 || regwr !== 1'b1 ||
        reg_dst !== 2'b10 || memtoreg !== 2'b10) begin
      failures++;
      $display("FAIL jal_jump state=%0d pc_wr=%b pc_src=%b regwr=%b dst=%b m2r=%b exp 9/1/10/1/10/10",
               state, pc_wr, pc_src, regwr, reg_dst, memtoreg);
    end
    @(posedge clk); #1;
    opcode = 6'b000000; funct = 6'b001000;
    @(posedge clk); #1; @(posedge clk); #1; #1;
    checks++;
    if (state !== 4'd9 || pc_wr !== 1'b1 || pc_src !== 2'b11 || regwr !== 1'b0) begin
      failures++;
      $display("FAIL jr_jump state=%0d pc_wr=%b pc_src=%b regwr=%b exp 9/1/11/0", state, pc_wr, pc_src, regwr);
    end
    @(posedge clk); #1;
    checks++;
    if (state !== 4'd0 || retired !== 32'd2) begin
      failures++;
      $display("FAIL jumps_done state=%0d retired=%0d exp 0/2", state, retired);
    end
  endtask

  // Starts from FETCH with a nonzero retired count left by the jump test.
  task automatic test_reset_mid_write();
    opcode = 6'b101011; funct = 6'b000000; mem_ack = 1'b1;
    @(posedge clk); #1; @(posedge clk); #1; @(posedge clk); #1;
    mem_ack = 1'b0; #1;
    checks++;
    if (state !== 4'd7 || mem_req !== 1'b1 || mem_we !== 1'b1 || iord !== 1'b1) begin
      failures++;
      $display("FAIL sw_wait state=%0d req=%b we=%b iord=%b exp 7/1/1/1", state, mem_req, mem_we, iord);
    end
    @(posedge clk); #1;
    checks++;
    if (state !== 4'd7 || mem_req !== 1'b1 || mem_we !== 1'b1) begin
      failures++;
      $display("FAIL sw_hold state=%0d req=%b we=%b exp 7/1/1", state, mem_req, mem_we);
    end
    #2; rst = 1'b0; #1;
    checks++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || state !== 4'd0) begin
      failures++;
      $display("FAIL async_reset req=%b we=%b state=%0d exp 0/0/0", mem_req, mem_we, state);
    end
    @(posedge clk); #1;
    rst = 1'b1; #1;
    checks++;
    if (state !== 4'd0 || retired !== 32'd0) begin
      failures++;
      $display("FAIL after_reset state=%0d retired=%0d exp 0/0", state, retired);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    opcode = 6'b111111; funct = 6'b000000; mem_ack = 1'b1;
    @(posedge clk); #1; #1;
    checks++;
    if (state !== 4'd1 || illegal !== 1'b0) begin
      failures++;
      $display("FAIL illegal_decode state=%0d illegal=%b exp 1/0", state, illegal);
    end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      checks++;
      if (state !== 4'd15 || illegal !== 1'b1 || mem_req !== 1'b0 || pc_wr !== 1'b0) begin
        failures++;
        $display("FAIL halt[%0d] state=%0d illegal=%b req=%b pc_wr=%b exp 15/1/0/0", i, state, illegal, mem_req, pc_wr);
      end
    end
    rst = 1'b0; #1;
    checks++;
    if (illegal !== 1'b0 || state !== 4'd0) begin
      failures++;
      $display("FAIL illegal_clear illegal=%b state=%0d exp 0/0", illegal, state);
    end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_itype();
    test_lw_wait();
    test_beq();
    test_jumps();
    test_reset_mid_write();
    test_illegal();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control sequencer for the MIPS core. It decodes the latched instruction fields and steps the shared datapath (PC, IR, register file, ALU, ALUOut register, and a single unified instruction/data memory port) through fetch, decode, execute, memory and write-back states, one state per cycle. Memory accesses wait on a req/ack handshake. It replaces the single-cycle combinational decode in the multi-cycle variant of the core.

## Interface
Parameters:
- `RST_PC_SRC`, default `2'b00`: `pc_src` value driven while in reset.

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-low reset
- `opcode`  in  6  IR[31:26]
- `funct`  in  6  IR[5:0]
- `zero`  in  1  ALU zero flag, combinational from the current ALU operands
- `mem_ack`  in  1  memory access completes this cycle
- `mem_req`  out  1  memory access request
- `mem_we`  out  1  write enable, qualified by `mem_req`
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `ir_wr`  out  1  load IR from memory read data
- `pc_wr`  out  1  load PC
- `pc_src`  out  2  PC source: 00 ALU result, 01 ALUOut, 10 {PC[31:28], IR[25:0], 2'b00}, 11 GPR rs
- `alusrc_a`  out  1  ALU A: 0 = PC, 1 = GPR rs
- `alusrc_b`  out  2  ALU B: 00 GPR rt, 01 constant 4, 10 ext32(imm), 11 sext(imm)<<2
- `aluop`  out  3  000 add, 001 sub, 010 or, 011 slt, 100 pass B
- `extop`  out  2  00 zero-extend, 01 sign-extend, 10 imm<<16
- `regwr`  out  1  GPR write enable
- `reg_dst`  out  2  write address: 00 rt, 01 rd, 10 $31
- `memtoreg`  out  2  write data: 00 ALUOut, 01 memory data, 10 PC (already PC+4)
- `illegal`  out  1  sticky: unsupported instruction decoded
- `state`  out  4  current state, for debug
- `retired`  out  32  count of completed instructions

## Operation
- States (encoding): FETCH 0, DECODE 1, EXEC_R 2, EXEC_I 3, MEM_ADDR 4, MEM_RD 5, MEM_WB 6, MEM_WR 7, BRANCH 8, JUMP 9, ALU_WB 10, HALT 15.
- All control outputs are Moore outputs decoded from the state, plus the latched `opcode`/`funct` where the state needs them. The only Mealy terms are `pc_wr` and `ir_wr` in FETCH (gated by `mem_ack`) and `pc_wr` in BRANCH (gated by `zero`).
- Every output not listed for a state is 0 in that state.
- FETCH:
  - Drives `mem_req=1`, `iord=0`, `alusrc_a=0`, `alusrc_b=01`, `aluop=add`.
  - On `mem_ack`: `ir_wr=1`, `pc_wr=1`, `pc_src=00`, then go to DECODE. Otherwise stay in FETCH.
- DECODE:
  - Drives `alusrc_a=0`, `alusrc_b=11`, `aluop=add`, so the branch target lands in ALUOut.
  - Next state by instruction:
    - addu / subu / slt → EXEC_R
    - jr → JUMP
    - ori / lui / addi → EXEC_I
    - lw / sw → MEM_ADDR
    - beq → BRANCH
    - j / jal → JUMP
    - anything else → HALT, setting `illegal`
- Opcode and funct encodings:
  - R-type: opcode 000000 with funct 100001 addu, 100011 subu, 101010 slt, 001000 jr.
  - I/J-type opcodes: ori 001101, lui 001111, addi 001000, lw 100011, sw 101011, beq 000100, j 000010, jal 000011.
- EXEC_R: `alusrc_a=1`, `alusrc_b=00`, `aluop` from funct (add/sub/slt). Next: ALU_WB.
- EXEC_I: `alusrc_a=1`, `alusrc_b=10`, settings per instruction below. Next: ALU_WB.
  - ori: `extop=00`, `aluop=or`
  - lui: `extop=10`, `aluop=pass B`
  - addi: `extop=01`, `aluop=add`
- ALU_WB: `regwr=1`, `memtoreg=00`, `reg_dst` = 01 for R-type, 00 for I-type. Next: FETCH.
- MEM_ADDR: `alusrc_a=1`, `alusrc_b=10`, `extop=01`, `aluop=add`. Next: MEM_RD for lw, MEM_WR for sw.
- MEM_RD: `mem_req=1`, `iord=1`. On `mem_ack` go to MEM_WB; otherwise stay.
- MEM_WB: `regwr=1`, `memtoreg=01`, `reg_dst=00`. Next: FETCH.
- MEM_WR: `mem_req=1`, `mem_we=1`, `iord=1`. On `mem_ack` go to FETCH; otherwise stay.
- BRANCH: `alusrc_a=1`, `alusrc_b=00`, `aluop=sub`, `pc_src=01`, `pc_wr=zero`. Next: FETCH.
- JUMP: `pc_wr=1`.
  - j: `pc_src=10`.
  - jal: `pc_src=10`, plus `regwr=1`, `reg_dst=10`, `memtoreg=10`.
  - jr: `pc_src=11`.
  - Next: FETCH.
- HALT: all enables 0, `illegal=1`, no exit except reset.
- `retired` increments by 1 (mod 2^32) on every transition into FETCH from a non-FETCH state.

## Timing
- Reset (`rst`=0, asynchronous):
  - `state` = FETCH, `illegal`=0, `retired`=0, `pc_src`=`RST_PC_SRC`.
  - While `rst` is low, every enable (`mem_req`, `mem_we`, `ir_wr`, `pc_wr`, `regwr`) is forced to 0.
  - Reset deasserted → first FETCH request appears in the same cycle.
- Handshake:
  - `mem_req`, `mem_we` and `iord` are held stable until the cycle in which `mem_ack`=1; the state advances on that edge.
  - `mem_ack` in a non-request state is ignored.
  - With `mem_ack` tied high, the fixed-latency instructions take:
    - 4 cycles: R-type, I-type ALU, sw
    - 5 cycles: lw
    - 3 cycles: beq, j, jal, jr
  - Each wait cycle on the memory adds exactly one cycle.
- Reset asserted mid-request drops `mem_req` immediately. The memory must discard the access.
- `pc_wr` and `regwr` are never asserted in the same cycle, except in JUMP for jal.

## Test plan
- Reset, then `mem_ack`=1 and the IR holds addu (000000/100001) → state sequence 0,1,2,10,0; `regwr`=1 with `reg_dst`=01 in the ALU_WB cycle; `retired`=1.
- lw with `mem_ack` low for 2 cycles in FETCH and 3 cycles in MEM_RD → `mem_req`/`iord` held stable throughout; total 10 cycles; `memtoreg`=01 in MEM_WB.
- beq with `zero`=1, then again with `zero`=0 → `pc_wr`=1 and `pc_src`=01 in BRANCH only when `zero`=1; both take 3 cycles.
- jal → JUMP cycle shows `pc_wr`=1, `pc_src`=10, `regwr`=1, `reg_dst`=10, `memtoreg`=10. Then jr (funct 001000) → `pc_src`=11.
- Opcode 111111 → `illegal`=1 and `state`=15 from the cycle after DECODE; it remains there for 20 cycles with `mem_req`=0; `rst` low clears it.
- Assert `rst` low during MEM_WR wait → `mem_req`/`mem_we` drop to 0 asynchronously; after release, `state`=0 and `retired`=0.
